serial_word_tx: RTL

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/ej2_pkg.sv | 11 +
 rtl/serial_word_tx.sv | 92 +++++++++
 2 files changed

// File: rtl/ej2_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector.
package ej2_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_word_tx.sv
// MSB-first parallel-to-serial transmitter with a load handshake and end-of-word pulse.
// Build option SERIAL_WORD_TX_LOOP_EN: endlessly repeat the last accepted word.
//
// state | meaning
// IDLE  | no word in flight, w = 0, ready for a new word
// SHIFT | a word is on w, one bit per cycle; ready again only on its last bit
module serial_word_tx
    import ej2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             last_bit;

`ifdef SERIAL_WORD_TX_LOOP_EN
    // Copy of the accepted word, replayed whenever no new word arrives in time.
    logic [WIDTH-1:0] word_q, word_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_WORD_TX_LOOP_EN
            word_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_WORD_TX_LOOP_EN
            word_q  <= word_d;
`endif
        end
    end

    always_comb begin
        last_bit   = (state_q == SHIFT) && (cnt_q == '0);
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;
        w          = (state_q == SHIFT) ? sreg_q[WIDTH-1] : 1'b0;
        w_valid    = (state_q == SHIFT);
        done       = last_bit;

        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_WORD_TX_LOOP_EN
        word_d  = word_q;
`endif

        if (accept) begin
            state_d = SHIFT;
            sreg_d  = data_in;
            cnt_d   = CNT_LAST;
`ifdef SERIAL_WORD_TX_LOOP_EN
            word_d  = data_in;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
            end else begin
`ifdef SERIAL_WORD_TX_LOOP_EN
                sreg_d  = word_q;
                cnt_d   = CNT_LAST;
`else
                state_d = IDLE;
                sreg_d  = '0;
`endif
            end
        end
    end

endmodule
